// File: rtl/ov5640_cap_ctrl_if.sv
// Pixel/control/frame-buffer signal bundle for ov5640_cap_ctrl.
// The master drives sensor and control inputs; the slave (the controller) drives write and status.
interface ov5640_cap_ctrl_if #(
   parameter int unsigned ADDR_W = 20
);
   logic              ov5640_vsync;
   logic              ov5640_href;
   logic [15:0]       pix_data;
   logic              pix_vld;
   logic              cap_start;
   logic              cap_cont;
   logic              cap_stop;
   logic              rd_lock;
   logic              fb_wr_en;
   logic [ADDR_W-1:0] fb_wr_addr;
   logic [15:0]       fb_wr_data;
   logic              buf_sel;
   logic              frame_done;
   logic              busy;
   logic              ovf;
   logic [15:0]       img_width;
   logic [15:0]       img_height;
   logic [7:0]        drop_cnt;

   modport master (
      output ov5640_vsync, ov5640_href, pix_data, pix_vld,
      output cap_start, cap_cont, cap_stop, rd_lock,
      input  fb_wr_en, fb_wr_addr, fb_wr_data, buf_sel, frame_done, busy,
      input  ovf, img_width, img_height, drop_cnt
   );

   modport slave (
      input  ov5640_vsync, ov5640_href, pix_data, pix_vld,
      input  cap_start, cap_cont, cap_stop, rd_lock,
      output fb_wr_en, fb_wr_addr, fb_wr_data, buf_sel, frame_done, busy,
      output ovf, img_width, img_height, drop_cnt
   );
endinterface

// File: rtl/ov5640_cap_ctrl.sv
// OV5640 frame capture controller: skip/arm/capture/commit into a ping-pong frame buffer.
// Define CAP_STATS_EN to build img_width/img_height/drop_cnt/ovf; otherwise they read 0.
module ov5640_cap_ctrl #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned IMG_W       = 640,
   parameter int unsigned IMG_H       = 480,
   parameter int unsigned SKIP_FRAMES = 10
) (
   input  logic             ov5640_pclk,
   input  logic             rst,
   ov5640_cap_ctrl_if.slave cap_if
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SKIP   = 3'd1;
   localparam logic [2:0] ST_ARM    = 3'd2;
   localparam logic [2:0] ST_CAP    = 3'd3;
   localparam logic [2:0] ST_COMMIT = 3'd4;

   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(IMG_W * IMG_H);
   localparam logic [15:0]       SKIP_N    = 16'(SKIP_FRAMES);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic              r_vsync_d1;
   logic              r_cont;
   logic              r_stop_pend;
   logic [15:0]       r_skip_cnt;
   logic [ADDR_W-1:0] r_pix_idx;
   logic              r_buf_sel;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_wr_data;

   logic w_vs_pos;
   logic w_start;
   logic w_wr_req;
   logic w_full;

   assign w_vs_pos = cap_if.ov5640_vsync & ~r_vsync_d1;
   assign w_start  = (r_state == ST_IDLE) & cap_if.cap_start;
   assign w_wr_req = (r_state == ST_CAP) & cap_if.pix_vld & cap_if.ov5640_href;
   assign w_full   = (r_pix_idx == FRAME_PIX);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (cap_if.cap_start) w_state_nxt = (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
         end
         ST_SKIP: begin
            if (cap_if.cap_stop) w_state_nxt = ST_IDLE;
            else if (w_vs_pos && (r_skip_cnt + 16'd1 == SKIP_N)) w_state_nxt = ST_ARM;
         end
         ST_ARM: begin
            if (cap_if.cap_stop) w_state_nxt = ST_IDLE;
            else if (w_vs_pos) w_state_nxt = ST_CAP;
         end
         ST_CAP: begin
            if (w_vs_pos) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            // The vsync that ended the frame also starts the next one.
            if (!r_cont || r_stop_pend || cap_if.cap_stop) w_state_nxt = ST_IDLE;
            else w_state_nxt = ST_CAP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ov5640_pclk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_vsync_d1  <= 1'b0;
         r_cont      <= 1'b0;
         r_stop_pend <= 1'b0;
         r_skip_cnt  <= '0;
         r_pix_idx   <= '0;
         r_buf_sel   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_vsync_d1 <= cap_if.ov5640_vsync;
         r_wr_en    <= 1'b0;
         if (w_start) begin
            r_cont      <= cap_if.cap_cont;
            r_skip_cnt  <= '0;
            r_stop_pend <= 1'b0;
         end
         if ((r_state == ST_SKIP) && w_vs_pos) r_skip_cnt <= r_skip_cnt + 16'd1;
         if ((r_state == ST_CAP) && cap_if.cap_stop) r_stop_pend <= 1'b1;
         if ((w_state_nxt == ST_CAP) && (r_state != ST_CAP)) begin
            r_pix_idx <= '0;
         end else if (w_wr_req && !w_full) begin
            r_pix_idx <= r_pix_idx + 1'b1;
         end
         if (w_wr_req && !w_full) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_buf_sel, r_pix_idx[ADDR_W-2:0]};
            r_wr_data <= cap_if.pix_data;
         end
         // A locked alternate buffer means the next frame overwrites the current one.
         if ((r_state == ST_COMMIT) && !cap_if.rd_lock) r_buf_sel <= ~r_buf_sel;
      end
   end

   assign cap_if.fb_wr_en   = r_wr_en;
   assign cap_if.fb_wr_addr = r_wr_addr;
   assign cap_if.fb_wr_data = r_wr_data;
   assign cap_if.buf_sel    = r_buf_sel;
   assign cap_if.frame_done = (r_state == ST_COMMIT);
   assign cap_if.busy       = (r_state != ST_IDLE);

`ifdef CAP_STATS_EN
   logic        r_href_d1;
   logic [15:0] r_line_w;
   logic [15:0] r_line_cnt;
   logic [15:0] r_last_w;
   logic [15:0] r_img_w;
   logic [15:0] r_img_h;
   logic [7:0]  r_drop;
   logic        r_ovf;
   logic        w_line_end;

   assign w_line_end = ~cap_if.ov5640_href & r_href_d1 & (r_line_w != 16'd0);

   always_ff @(posedge ov5640_pclk) begin
      if (rst) begin
         r_href_d1  <= 1'b0;
         r_line_w   <= '0;
         r_line_cnt <= '0;
         r_last_w   <= '0;
         r_img_w    <= '0;
         r_img_h    <= '0;
         r_drop     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_href_d1 <= cap_if.ov5640_href;
         if (r_state == ST_COMMIT) begin
            r_img_w <= r_last_w;
            r_img_h <= r_line_cnt;
            if (cap_if.rd_lock && (r_drop != 8'hff)) r_drop <= r_drop + 8'd1;
         end
         // Line measurement restarts at every frame start; in CAP the restart waits for COMMIT.
         if ((r_state == ST_COMMIT) || (w_vs_pos && (r_state != ST_CAP))) begin
            r_line_w   <= '0;
            r_line_cnt <= '0;
            r_last_w   <= '0;
         end else if (w_line_end) begin
            if (r_line_cnt != 16'hffff) r_line_cnt <= r_line_cnt + 16'd1;
            r_last_w <= r_line_w;
            r_line_w <= '0;
         end else if (cap_if.pix_vld && cap_if.ov5640_href && (r_line_w != 16'hffff)) begin
            r_line_w <= r_line_w + 16'd1;
         end
         if (w_start) r_ovf <= 1'b0;
         else if (w_wr_req && w_full) r_ovf <= 1'b1;
      end
   end

   assign cap_if.img_width  = r_img_w;
   assign cap_if.img_height = r_img_h;
   assign cap_if.drop_cnt   = r_drop;
   assign cap_if.ovf        = r_ovf;
`else
   assign cap_if.img_width  = 16'd0;
   assign cap_if.img_height = 16'd0;
   assign cap_if.drop_cnt   = 8'd0;
   assign cap_if.ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_cap_ctrl.sv
// Directed bench for ov5640_cap_ctrl: 4x3 sensor frames, SKIP_FRAMES=2, plus an IMG_H=2 instance
// fed the same stream to exercise overflow.
module tb_ov5640_cap_ctrl;
   localparam int unsigned AW = 8;
`ifdef CAP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync, href, pix_vld, cap_start, cap_cont, cap_stop, rd_lock;
   logic [15:0] pix_data;

   always #5 clk = ~clk;

   ov5640_cap_ctrl_if #(.ADDR_W(AW)) if_a ();
   ov5640_cap_ctrl_if #(.ADDR_W(AW)) if_b ();

   assign if_a.ov5640_vsync = vsync;
   assign if_a.ov5640_href  = href;
   assign if_a.pix_data     = pix_data;
   assign if_a.pix_vld      = pix_vld;
   assign if_a.cap_start    = cap_start;
   assign if_a.cap_cont     = cap_cont;
   assign if_a.cap_stop     = cap_stop;
   assign if_a.rd_lock      = rd_lock;
   assign if_b.ov5640_vsync = vsync;
   assign if_b.ov5640_href  = href;
   assign if_b.pix_data     = pix_data;
   assign if_b.pix_vld      = pix_vld;
   assign if_b.cap_start    = cap_start;
   assign if_b.cap_cont     = cap_cont;
   assign if_b.cap_stop     = cap_stop;
   assign if_b.rd_lock      = rd_lock;

   ov5640_cap_ctrl #(.ADDR_W(AW), .IMG_W(4), .IMG_H(3), .SKIP_FRAMES(2)) dut_a (
      .ov5640_pclk (clk),
      .rst         (rst),
      .cap_if      (if_a.slave)
   );

   ov5640_cap_ctrl #(.ADDR_W(AW), .IMG_W(4), .IMG_H(2), .SKIP_FRAMES(2)) dut_b (
      .ov5640_pclk (clk),
      .rst         (rst),
      .cap_if      (if_b.slave)
   );

   logic [AW-1:0] addr_q[$];
   logic [15:0]   data_q[$];
   logic          done_buf_q[$];
   int unsigned   wr_b_cnt = 0;

   always @(negedge clk) begin
      if (if_a.fb_wr_en) begin
         addr_q.push_back(if_a.fb_wr_addr);
         data_q.push_back(if_a.fb_wr_data);
      end
      if (if_a.frame_done) done_buf_q.push_back(if_a.buf_sel);
      if (if_b.fb_wr_en) wr_b_cnt++;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      ticks(3);
      vsync = 1'b0;
      ticks(2);
   endtask

   task automatic lines(input logic [7:0] tag);
      for (int l = 0; l < 3; l++) begin
         href = 1'b1;
         for (int p = 0; p < 4; p++) begin
            pix_vld  = 1'b1;
            pix_data = {tag, 4'(l), 4'(p)};
            tick();
         end
         pix_vld = 1'b0;
         href    = 1'b0;
         ticks(2);
      end
   endtask

   task automatic frame(input logic [7:0] tag);
      vs_pulse();
      lines(tag);
   endtask

   task automatic pulse_start(input logic cont);
      cap_cont  = cont;
      cap_start = 1'b1;
      tick();
      cap_start = 1'b0;
   endtask

   task automatic pulse_stop();
      cap_stop = 1'b1;
      tick();
      cap_stop = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();
   endtask

   int ab;
   int db;

   initial begin
      rst = 1'b1; vsync = 1'b0; href = 1'b0; pix_vld = 1'b0; pix_data = '0;
      cap_start = 1'b0; cap_cont = 1'b0; cap_stop = 1'b0; rd_lock = 1'b0;
      ticks(2);
      chk("rst_busy", 32'(if_a.busy), 0);
      chk("rst_wr_en", 32'(if_a.fb_wr_en), 0);
      chk("rst_buf_sel", 32'(if_a.buf_sel), 0);
      chk("rst_done", 32'(if_a.frame_done), 0);
      chk("rst_img_w", 32'(if_a.img_width), 0);
      chk("rst_drop", 32'(if_a.drop_cnt), 0);
      chk("rst_ovf", 32'(if_a.ovf), 0);
      rst = 1'b0;
      tick();

      // Single frame after two skipped frames
      pulse_start(1'b0);
      chk("a_busy_skip", 32'(if_a.busy), 1);
      frame(8'd1);
      frame(8'd2);
      chk("a_skip_no_wr", 32'(addr_q.size()), 0);
      frame(8'd3);
      vs_pulse();
      ticks(2);
      chk("a_wr_cnt", 32'(addr_q.size()), 12);
      chk("a_addr_first", 32'(addr_q[0]), 0);
      chk("a_addr_last", 32'(addr_q[11]), 11);
      chk("a_data_first", 32'(data_q[0]), 32'h0300);
      chk("a_data_last", 32'(data_q[11]), 32'h0323);
      chk("a_done_cnt", 32'(done_buf_q.size()), 1);
      chk("a_done_buf", 32'(done_buf_q[0]), 0);
      chk("a_buf_sel", 32'(if_a.buf_sel), 1);
      chk("a_idle", 32'(if_a.busy), 0);
      chk("a_img_w", 32'(if_a.img_width), STATS ? 4 : 0);
      chk("a_img_h", 32'(if_a.img_height), STATS ? 3 : 0);
      chk("b_wr_cnt", wr_b_cnt, 8);
      chk("b_ovf", 32'(if_b.ovf), STATS ? 1 : 0);
      chk("b_img_h", 32'(if_b.img_height), STATS ? 3 : 0);

      // Continuous, rd_lock low, stop requested mid-CAP
      do_reset();
      chk("b_rst_buf_sel", 32'(if_a.buf_sel), 0);
      chk("b_rst_img_w", 32'(if_a.img_width), 0);
      ab = addr_q.size();
      db = done_buf_q.size();
      pulse_start(1'b1);
      frame(8'd1);
      frame(8'd2);
      frame(8'd3);
      frame(8'd4);
      frame(8'd5);
      frame(8'd6);
      pulse_stop();
      chk("c_busy_after_stop", 32'(if_a.busy), 1);
      vs_pulse();
      ticks(2);
      chk("c_done_cnt", 32'(done_buf_q.size() - db), 4);
      chk("c_done_buf0", 32'(done_buf_q[db]), 0);
      chk("c_done_buf1", 32'(done_buf_q[db+1]), 1);
      chk("c_done_buf2", 32'(done_buf_q[db+2]), 0);
      chk("c_done_buf3", 32'(done_buf_q[db+3]), 1);
      chk("c_wr_cnt", 32'(addr_q.size() - ab), 48);
      chk("c_addr_f0", 32'(addr_q[ab]), 0);
      chk("c_addr_f1", 32'(addr_q[ab+12]), 32'h80);
      chk("c_addr_f2", 32'(addr_q[ab+24]), 0);
      chk("c_addr_f3", 32'(addr_q[ab+36]), 32'h80);
      chk("c_addr_f3_last", 32'(addr_q[ab+47]), 32'h8b);
      chk("c_idle", 32'(if_a.busy), 0);
      chk("c_buf_sel", 32'(if_a.buf_sel), 0);

      // Stop during SKIP, then start+stop in the same cycle
      db = done_buf_q.size();
      ab = addr_q.size();
      pulse_start(1'b1);
      frame(8'd1);
      pulse_stop();
      chk("d_skip_stop_idle", 32'(if_a.busy), 0);
      frame(8'd2);
      frame(8'd3);
      chk("d_no_done", 32'(done_buf_q.size() - db), 0);
      chk("d_no_wr", 32'(addr_q.size() - ab), 0);
      cap_cont = 1'b1; cap_start = 1'b1; cap_stop = 1'b1;
      tick();
      cap_start = 1'b0; cap_stop = 1'b0;
      chk("d_start_wins", 32'(if_a.busy), 1);
      pulse_stop();
      chk("d_stop_again", 32'(if_a.busy), 0);

      // Continuous with rd_lock across the second commit, then reset mid-line
      do_reset();
      ab = addr_q.size();
      db = done_buf_q.size();
      pulse_start(1'b1);
      frame(8'd1);
      frame(8'd2);
      frame(8'd3);
      frame(8'd4);
      rd_lock = 1'b1;
      frame(8'd5);
      chk("e_buf_held", 32'(if_a.buf_sel), 1);
      chk("e_drop1", 32'(if_a.drop_cnt), STATS ? 1 : 0);
      chk("e_done_cnt", 32'(done_buf_q.size() - db), 2);
      chk("e_done_buf1", 32'(done_buf_q[db+1]), 1);
      chk("e_rewrite_base", 32'(addr_q[ab+24]), 32'h80);
      chk("e_rewrite_last", 32'(addr_q[ab+35]), 32'h8b);
      vs_pulse();
      chk("e_drop2", 32'(if_a.drop_cnt), STATS ? 2 : 0);
      chk("e_buf_held2", 32'(if_a.buf_sel), 1);
      href = 1'b1; pix_vld = 1'b1; pix_data = 16'h0abc;
      ticks(2);
      chk("e_writing", 32'(if_a.fb_wr_en), 1);
      rst = 1'b1;
      tick();
      chk("e_rst_wr_en", 32'(if_a.fb_wr_en), 0);
      chk("e_rst_busy", 32'(if_a.busy), 0);
      chk("e_rst_buf_sel", 32'(if_a.buf_sel), 0);
      chk("e_rst_drop", 32'(if_a.drop_cnt), 0);
      chk("e_rst_img_h", 32'(if_a.img_height), 0);
      rst = 1'b0; href = 1'b0; pix_vld = 1'b0; rd_lock = 1'b0;
      ticks(2);
      ab = addr_q.size();
      db = done_buf_q.size();
      pulse_start(1'b0);
      frame(8'd1);
      frame(8'd2);
      chk("f_reskip_no_wr", 32'(addr_q.size() - ab), 0);
      frame(8'd3);
      vs_pulse();
      ticks(2);
      chk("f_wr_cnt", 32'(addr_q.size() - ab), 12);
      chk("f_addr_first", 32'(addr_q[ab]), 0);
      chk("f_done_cnt", 32'(done_buf_q.size() - db), 1);
      chk("f_buf_sel", 32'(if_a.buf_sel), 1);
      chk("f_idle", 32'(if_a.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ov5640_cap_ctrl.md
Name: ov5640_cap_ctrl

Overview:
- Frame capture controller in the camera pixel-clock domain.
- Consumes the packed 16-bit pixel stream (pix_data/pix_vld) plus the raw ov5640_vsync/ov5640_href, and sequences whole-frame writes into a ping-pong frame buffer.
- Runs skip, arm, capture, frame-done sequencing; measures the actual image width/height; drops frames when the reader still holds the alternate buffer.

Parameters:
- ADDR_W, 20, frame buffer word-address width; buffer 0 base = 0, buffer 1 base = 2^(ADDR_W-1).
- IMG_W, 640, expected pixels per line.
- IMG_H, 480, expected lines per frame.
- SKIP_FRAMES, 10, frames discarded after each cap_start before capture begins (sensor settling); 0 is legal.

Ports:
- ov5640_pclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ov5640_vsync  in  1  raw sensor vsync (high pulse between frames).
- ov5640_href  in  1  raw sensor line valid.
- pix_data  in  16  packed pixel.
- pix_vld  in  1  one-cycle strobe per packed pixel; only meaningful while href high.
- cap_start  in  1  pulse: arm capture.
- cap_cont  in  1  sampled at cap_start: 1 = continuous, 0 = single frame.
- cap_stop  in  1  pulse: stop after the current frame ends.
- rd_lock  in  1  reader owns buffer ~buf_sel; must not be switched to.
- fb_wr_en  out  1  write strobe to frame buffer.
- fb_wr_addr  out  ADDR_W  write word address.
- fb_wr_data  out  16  write data.
- buf_sel  out  1  buffer currently being written.
- frame_done  out  1  one-cycle pulse, frame committed.
- busy  out  1  state != IDLE.
- ovf  out  1  sticky: pixel count exceeded IMG_W*IMG_H in a frame.
- img_width  out  16  measured pixels in the last complete line of the last frame.
- img_height  out  16  measured lines of the last frame.
- drop_cnt  out  8  frames dropped due to rd_lock; saturates at 255.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; ovf 0.
- vs_pos = ov5640_vsync & ~vsync_d1. href_neg = ~ov5640_href & href_d1. Edge registers reset to 0.
- States:
  - IDLE: on cap_start, latch mode, clear skip counter and ovf, go to SKIP if SKIP_FRAMES>0, else ARM.
  - SKIP: each vs_pos increments the skip counter; at count==SKIP_FRAMES go to ARM.
  - ARM: wait for the next vs_pos, then go to CAP. The SKIP->ARM transition cycle does not itself count as a frame start.
  - CAP: the frame in progress is written. The next vs_pos ends it and moves to COMMIT for exactly one cycle.
  - COMMIT:
    - Pulse frame_done; latch img_height = line count and img_width = last nonzero line width.
    - If rd_lock = 0: toggle buf_sel. If rd_lock = 1: keep buf_sel (next frame overwrites it), drop_cnt++, frame_done is still pulsed.
    - If mode single or stop_pending: go to IDLE. Else go to CAP with the pixel address cleared.
    - The vs_pos that caused COMMIT also starts the next frame; no frame is skipped.
- Write path, CAP only:
  - fb_wr_en = pix_vld & href_d-aligned data.
  - fb_wr_data = pix_data, registered, 1-cycle latency.
  - fb_wr_addr = {buf_sel, pix_idx[ADDR_W-2:0]}; pix_idx increments after each write.
  - When pix_idx == IMG_W*IMG_H, writes are suppressed and ovf is set (sticky until the next cap_start).
- Measurement: line_w counts pix_vld during href. On href_neg with line_w != 0: line count++, hold line_w as last width, clear line_w. Counters are 16-bit and saturate.
- cap_stop:
  - In CAP: sets stop_pending; the frame finishes normally.
  - In SKIP/ARM: go straight to IDLE, no frame_done.
  - In IDLE: ignored.
- cap_start outside IDLE is ignored. cap_start and cap_stop in the same IDLE cycle: start wins, stop is ignored.
- rst mid-frame: immediate IDLE, fb_wr_en 0, buf_sel 0; measurement registers cleared.

Optional Feature:
- CAP_STATS_EN defined: img_width, img_height, drop_cnt and ovf are implemented as above.
- Undefined: these four outputs are tied to 0 and their counters are not built. Drop behaviour (buf_sel held on rd_lock) is unchanged.

Test Plan:
- SKIP_FRAMES=2, single mode, 4x3 frames (4 pix_vld per href, 3 hrefs): frames 1–2 produce no fb_wr_en. The third frame gives 12 writes at addr 0..11, then frame_done, img_width=4, img_height=3, buf_sel=1, state IDLE.
- Continuous mode, rd_lock=0, 3 frames: buf_sel sequence 0,1,0. Addresses restart at base 0 / 2^(ADDR_W-1) each frame. Three frame_done pulses.
- Continuous, rd_lock=1 across the second commit: buf_sel stays 1, drop_cnt=1, third frame rewrites buffer 1 from offset 0.
- IMG_W=4, IMG_H=2, sensor sends a 4x3 frame: only 8 writes, ovf=1, img_height=3.
- cap_stop mid-CAP in continuous mode: current frame completes with frame_done, then IDLE. cap_stop during SKIP: IDLE, no frame_done.
- rst asserted mid-line: next cycle fb_wr_en=0, busy=0, buf_sel=0; a following cap_start re-runs the full skip count.
